// File: rtl/switch_pkg.sv
// Shared types and constants for the switch ingress path: ingress FSM states,
// word geometry and the checksum-clear helper.
package switch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DROP  = 3'd4
  } ingress_state_t;

  localparam int          WORD_BYTES         = 4;
  localparam logic [15:0] ZERO_HALF          = 16'h0000;
  localparam int          CKSUM_WORD_DEFAULT = 6;

  // IPv4 header checksum sits in the upper half of its word.
  function automatic logic [31:0] clear_high_half(input logic [31:0] word);
    return {ZERO_HALF, word[15:0]};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; a short final word is
// zero-padded in its low bytes. The word/strobe outputs are combinational.
module byte_packer
  import switch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic [31:0] word,
  output logic        word_stb,
  output logic        word_eop
);

  logic [1:0]  idx_r;
  logic [31:0] acc_r;
  logic [31:0] merged_s;

  // Merge the incoming byte into its lane of the partial word.
  always_comb begin
    merged_s = acc_r;
    case (idx_r)
      2'd0:    merged_s[31:24] = in_data;
      2'd1:    merged_s[23:16] = in_data;
      2'd2:    merged_s[15:8]  = in_data;
      2'd3:    merged_s[7:0]   = in_data;
      default: merged_s = acc_r;
    endcase
  end

  assign word     = merged_s;
  assign word_stb = in_valid && ((idx_r == 2'(WORD_BYTES - 1)) || in_last);
  assign word_eop = in_valid && in_last;

  // Lane index and partial word; both restart once a word is emitted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r <= 2'd0;
      acc_r <= 32'd0;
    end else if (word_stb) begin
      idx_r <= 2'd0;
      acc_r <= 32'd0;
    end else if (in_valid) begin
      idx_r <= idx_r + 2'd1;
      acc_r <= merged_s;
    end
  end

endmodule

// File: rtl/pkt_ingress_loader.sv
// Ingress loader: byte stream -> packet SRAM words, then ready/done handoff.
// Define CKSUM_CLEAR_EN to zero the IPv4 checksum half of word CKSUM_WORD.
module pkt_ingress_loader
  import switch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256,
  parameter int CKSUM_WORD = CKSUM_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  pkt_ready,
  output logic [15:0]           pkt_len,
  input  logic                  pkt_done,
  output logic [15:0]           drop_cnt
);

`ifdef CKSUM_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif
  localparam logic [15:0] MAX_BYTES = 16'(MAX_WORDS * WORD_BYTES);

  ingress_state_t        state_r, state_s;
  logic [15:0]           cnt_r;
  logic [ADDR_WIDTH-1:0] waddr_r, wr_addr_s;
  logic                  accept_s, over_s, pk_valid_s, drop_s, ready_s, cksum_hit_s;
  logic                  pk_stb_s, pk_eop_s;
  logic [31:0]           pk_word_s, wr_data_s;

  assign accept_s   = s_valid && s_ready;
  assign over_s     = (state_r == ST_RECV) && (cnt_r == MAX_BYTES);
  assign pk_valid_s = accept_s && !over_s && ((state_r == ST_IDLE) || (state_r == ST_RECV));
  assign drop_s     = accept_s && s_last && ((state_r == ST_DROP) || over_s);
  assign wr_addr_s  = (state_r == ST_IDLE) ? '0 : waddr_r;
  assign cksum_hit_s = (wr_addr_s == ADDR_WIDTH'(CKSUM_WORD));
  assign ready_s    = (state_s == ST_IDLE) || (state_s == ST_RECV) || (state_s == ST_DROP);

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s_data),
    .in_valid (pk_valid_s),
    .in_last  (s_last),
    .word     (pk_word_s),
    .word_stb (pk_stb_s),
    .word_eop (pk_eop_s)
  );

  // Write data, with the optional checksum-half clear.
  always_comb begin
    wr_data_s = pk_word_s;
    if (CLEAR_EN && cksum_hit_s) begin
      wr_data_s = clear_high_half(pk_word_s);
    end else begin
      wr_data_s = pk_word_s;
    end
  end

  // Next-state logic; the oversize byte diverts to DROP without a write.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = pk_valid_s ? (pk_eop_s ? ST_FLUSH : ST_RECV) : ST_IDLE;
      ST_RECV: begin
        if (accept_s && over_s) begin
          state_s = s_last ? ST_IDLE : ST_DROP;
        end else if (pk_eop_s) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_FLUSH: state_s = ST_HOLD;
      ST_HOLD:  state_s = pkt_done ? ST_IDLE : ST_HOLD;
      ST_DROP:  state_s = (accept_s && s_last) ? ST_IDLE : ST_DROP;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State, byte count and word address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      s_ready <= 1'b0;
      cnt_r   <= 16'd0;
      waddr_r <= '0;
    end else begin
      state_r <= state_s;
      s_ready <= ready_s;
      if (state_r == ST_IDLE) begin
        cnt_r   <= pk_valid_s ? 16'd1 : 16'd0;
        waddr_r <= pk_stb_s ? ADDR_WIDTH'(1) : '0;
      end else begin
        if (pk_valid_s) cnt_r <= cnt_r + 16'd1;
        if (pk_stb_s) waddr_r <= waddr_r + ADDR_WIDTH'(1);
      end
    end
  end

  // Registered SRAM port, handshake and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      pkt_ready <= 1'b0;
      pkt_len   <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      mem_we <= pk_stb_s;
      if (pk_stb_s) begin
        mem_addr  <= wr_addr_s;
        mem_wdata <= wr_data_s;
      end
      if (state_r == ST_FLUSH) begin
        pkt_ready <= 1'b1;
        pkt_len   <= cnt_r;
      end else if ((state_r == ST_HOLD) && pkt_done) begin
        pkt_ready <= 1'b0;
      end
      if (drop_s && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pkt_ingress_loader.sv
// Directed self-checking bench for pkt_ingress_loader; a second instance with
// MAX_WORDS=4 covers the oversize/drop path.
module tb_pkt_ingress_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid, s_last, pkt_done, sel;

  logic        rdy_b, we_b, prdy_b, rdy_s, we_s, prdy_s;
  logic [7:0]  addr_b, addr_s;
  logic [31:0] wd_b, wd_s;
  logic [15:0] plen_b, plen_s, dcnt_b, dcnt_s;

  logic        valid_b, valid_s;
  logic        rdy_m, we_m, prdy_m;
  logic [7:0]  addr_m;
  logic [31:0] wd_m;
  logic [15:0] plen_m, dcnt_m;

  assign valid_b = s_valid & ~sel;
  assign valid_s = s_valid & sel;
  assign rdy_m   = sel ? rdy_s  : rdy_b;
  assign we_m    = sel ? we_s   : we_b;
  assign prdy_m  = sel ? prdy_s : prdy_b;
  assign addr_m  = sel ? addr_s : addr_b;
  assign wd_m    = sel ? wd_s   : wd_b;
  assign plen_m  = sel ? plen_s : plen_b;
  assign dcnt_m  = sel ? dcnt_s : dcnt_b;

  pkt_ingress_loader dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(valid_b), .s_last(s_last),
    .s_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .pkt_ready(prdy_b), .pkt_len(plen_b), .pkt_done(pkt_done & ~sel), .drop_cnt(dcnt_b)
  );

  pkt_ingress_loader #(.MAX_WORDS(4)) dut_small (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(valid_s), .s_last(s_last),
    .s_ready(rdy_s), .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wd_s),
    .pkt_ready(prdy_s), .pkt_len(plen_s), .pkt_done(pkt_done & sel), .drop_cnt(dcnt_s)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  pkt [0:63];
  logic [31:0] wq_a [$];
  logic [31:0] wq_d [$];
  logic [31:0] exp6;

  always @(negedge clk) begin
    if (we_m) begin
      wq_a.push_back(32'(addr_m));
      wq_d.push_back(wd_m);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int k, input logic [31:0] ea, input logic [31:0] ed);
    check_eq({tag, "_present"}, 32'(k < wq_a.size()), 32'd1);
    if (k < wq_a.size()) begin
      check_eq({tag, "_addr"}, wq_a[k], ea);
      check_eq({tag, "_data"}, wq_d[k], ed);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int n, input bit with_last);
    int t;
    for (int i = 0; i < n; i++) begin
      s_data  = pkt[i];
      s_valid = 1'b1;
      s_last  = with_last && (i == n - 1);
      t = 0;
      while (!rdy_m && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
      check_eq("ready_wait", 32'(t < 100), 32'd1);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pulse_done();
    pkt_done = 1'b1;
    @(posedge clk);
    #1;
    pkt_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; pkt_done = 1'b0;
    idle(3);
    check_eq("rst_s_ready", 32'(rdy_b), 32'd0);
    check_eq("rst_s_ready_small", 32'(rdy_s), 32'd0);
    check_eq("rst_mem_we", 32'(we_b), 32'd0);
    check_eq("rst_mem_addr", 32'(addr_b), 32'd0);
    check_eq("rst_mem_wdata", wd_b, 32'd0);
    check_eq("rst_pkt_ready", 32'(prdy_b), 32'd0);
    check_eq("rst_pkt_len", 32'(plen_b), 32'd0);
    check_eq("rst_drop_cnt", 32'(dcnt_b), 32'd0);
    rst = 1'b1;
    idle(2);
    check_eq("idle_s_ready", 32'(rdy_b), 32'd1);

    // 8-byte packet 00..07
    for (int i = 0; i < 8; i++) pkt[i] = 8'(i);
    wq_a.delete(); wq_d.delete();
    send(8, 1'b1);
    check_eq("t1_we_latency", 32'(we_m), 32'd1);
    check_eq("t1_last_addr", 32'(addr_m), 32'd1);
    check_eq("t1_prdy_early", 32'(prdy_m), 32'd0);
    idle(1);
    check_eq("t1_prdy", 32'(prdy_m), 32'd1);
    check_eq("t1_len", 32'(plen_m), 32'd8);
    check_eq("t1_we_pulse", 32'(we_m), 32'd0);
    check_eq("t1_nwrites", 32'(wq_a.size()), 32'd2);
    check_wr("t1_w0", 0, 32'd0, 32'h00010203);
    check_wr("t1_w1", 1, 32'd1, 32'h04050607);
    check_eq("t1_hold_ready", 32'(rdy_m), 32'd0);
    pulse_done();
    check_eq("t1_done_prdy", 32'(prdy_m), 32'd0);
    check_eq("t1_done_ready", 32'(rdy_m), 32'd1);

    // 30-byte packet with checksum word AA BB CC DD
    for (int i = 0; i < 30; i++) pkt[i] = 8'(i);
    pkt[24] = 8'hAA; pkt[25] = 8'hBB; pkt[26] = 8'hCC; pkt[27] = 8'hDD;
`ifdef CKSUM_CLEAR_EN
    exp6 = 32'h0000CCDD;
`else
    exp6 = 32'hAABBCCDD;
`endif
    wq_a.delete(); wq_d.delete();
    send(30, 1'b1);
    idle(1);
    check_eq("t2_prdy", 32'(prdy_m), 32'd1);
    check_eq("t2_len", 32'(plen_m), 32'd30);
    check_eq("t2_nwrites", 32'(wq_a.size()), 32'd8);
    check_wr("t2_w0", 0, 32'd0, 32'h00010203);
    check_wr("t2_w5", 5, 32'd5, 32'h14151617);
    check_wr("t2_w6", 6, 32'd6, exp6);
    check_wr("t2_w7", 7, 32'd7, 32'h1C1D0000);
    pulse_done();

    // single-byte packet
    pkt[0] = 8'h5A;
    wq_a.delete(); wq_d.delete();
    send(1, 1'b1);
    idle(1);
    check_eq("t3_prdy", 32'(prdy_m), 32'd1);
    check_eq("t3_len", 32'(plen_m), 32'd1);
    check_eq("t3_nwrites", 32'(wq_a.size()), 32'd1);
    check_wr("t3_w0", 0, 32'd0, 32'h5A000000);
    idle(3);
    check_eq("t3_hold_ready", 32'(rdy_m), 32'd0);
    pulse_done();
    check_eq("t3_done_ready", 32'(rdy_m), 32'd1);

    // oversize on the MAX_WORDS=4 instance
    sel = 1'b1;
    for (int i = 0; i < 20; i++) pkt[i] = 8'h40 + 8'(i);
    wq_a.delete(); wq_d.delete();
    send(20, 1'b1);
    idle(3);
    check_eq("t4_nwrites", 32'(wq_a.size()), 32'd4);
    check_wr("t4_w3", 3, 32'd3, 32'h4C4D4E4F);
    check_eq("t4_no_prdy", 32'(prdy_m), 32'd0);
    check_eq("t4_drop_cnt", 32'(dcnt_m), 32'd1);
    check_eq("t4_ready", 32'(rdy_m), 32'd1);
    pkt[0] = 8'hDE; pkt[1] = 8'hAD; pkt[2] = 8'hBE; pkt[3] = 8'hEF;
    wq_a.delete(); wq_d.delete();
    send(4, 1'b1);
    idle(1);
    check_eq("t4_next_prdy", 32'(prdy_m), 32'd1);
    check_eq("t4_next_len", 32'(plen_m), 32'd4);
    check_wr("t4_next_w0", 0, 32'd0, 32'hDEADBEEF);
    pulse_done();
    sel = 1'b0;

    // pkt_done in IDLE is ignored; traffic held off during HOLD
    pulse_done();
    check_eq("t5_idle_done_prdy", 32'(prdy_m), 32'd0);
    check_eq("t5_idle_done_ready", 32'(rdy_m), 32'd1);
    pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03; pkt[3] = 8'h04;
    send(4, 1'b1);
    idle(1);
    check_eq("t5_prdy", 32'(prdy_m), 32'd1);
    wq_a.delete(); wq_d.delete();
    s_data = 8'h11; s_valid = 1'b1; s_last = 1'b0;
    idle(4);
    check_eq("t5_blocked_ready", 32'(rdy_m), 32'd0);
    check_eq("t5_blocked_writes", 32'(wq_a.size()), 32'd0);
    pulse_done();
    check_eq("t5_freed_ready", 32'(rdy_m), 32'd1);
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; pkt[3] = 8'h44;
    send(4, 1'b1);
    idle(1);
    check_eq("t5_nwrites", 32'(wq_a.size()), 32'd1);
    check_wr("t5_w0", 0, 32'd0, 32'h11223344);
    check_eq("t5_len", 32'(plen_m), 32'd4);
    pulse_done();

    // reset mid-packet
    for (int i = 0; i < 9; i++) pkt[i] = 8'h90 + 8'(i);
    send(5, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("t6_rst_ready", 32'(rdy_m), 32'd0);
    check_eq("t6_rst_we", 32'(we_m), 32'd0);
    check_eq("t6_rst_addr", 32'(addr_m), 32'd0);
    check_eq("t6_rst_wdata", wd_m, 32'd0);
    check_eq("t6_rst_prdy", 32'(prdy_m), 32'd0);
    check_eq("t6_rst_len", 32'(plen_m), 32'd0);
    check_eq("t6_rst_drop_small", 32'(dcnt_s), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    pkt[0] = 8'hA0; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3;
    wq_a.delete(); wq_d.delete();
    send(4, 1'b1);
    idle(1);
    check_eq("t6_nwrites", 32'(wq_a.size()), 32'd1);
    check_wr("t6_w0", 0, 32'd0, 32'hA0A1A2A3);
    check_eq("t6_prdy", 32'(prdy_m), 32'd1);
    check_eq("t6_len", 32'(plen_m), 32'd4);
    pulse_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
